// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_MEM  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_owner_e;

    // Command latched from the winning port at grant time.
    typedef struct packed {
        arb_owner_e          owner;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } arb_cmd_t;

    // True when a word address falls inside the backing memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       mem_size);
        return addr < ADDR_W'(mem_size);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core fetch/data ports and the single memory port, bundled for the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    // Fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    // Data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    // Status
    logic              bus_err;
    logic              core_stall;

    // Memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Arbiter view
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output i_rdata, i_ack,
        output d_rdata, d_ack,
        output bus_err, core_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    // Core + memory view
    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  i_rdata, i_ack,
        input  d_rdata, d_ack,
        input  bus_err, core_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Memory-wait watchdog: counts cycles while enabled, flags the last allowed cycle.
module mem_port_arbiter_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

    // Count wait cycles; holds at the expiry value until cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory between the fetch and data ports of the core.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 256,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned DATA_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int unsigned GCNT_W = $clog2(DATA_MAX + 1);

    arb_state_e         state;
    arb_cmd_t           cmd;
    logic [GCNT_W-1:0]  gnt_cnt;
    logic               mem_req_q;
    logic               i_ack_q;
    logic               d_ack_q;
    logic               err_q;
    logic [DATA_W-1:0]  i_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;

    logic               req_any_c;
    logic               fetch_wins_c;
    logic               win_in_range_c;
    arb_cmd_t           win_c;
    logic               to_expired_c;

    logic               done_c;
    logic               done_err_c;
    arb_owner_e         done_owner_c;
    logic               done_we_c;
    logic [DATA_W-1:0]  done_data_c;

    // Watchdog runs only while an access is outstanding at the memory.
    mem_port_arbiter_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr       (state != ARB_MEM),
        .en        (state == ARB_MEM),
        .expired_c (to_expired_c)
    );

    // Arbitration: data wins unless it has used up its quota while fetch waits.
    always_comb begin
        req_any_c    = bus.i_req || bus.d_req;
        fetch_wins_c = bus.i_req && (!bus.d_req || (gnt_cnt == GCNT_W'(DATA_MAX)));
        win_c        = '0;
        if (fetch_wins_c) begin
            win_c.owner = ARB_OWN_I;
            win_c.we    = 1'b0;
            win_c.addr  = bus.i_addr;
            win_c.wdata = '0;
        end else begin
            win_c.owner = ARB_OWN_D;
            win_c.we    = bus.d_we;
            win_c.addr  = bus.d_addr;
            win_c.wdata = bus.d_wdata;
        end
        win_in_range_c = addr_in_range(win_c.addr, MEM_SIZE);
    end

    // Completion event: range error in IDLE, or memory ack / timeout in MEM.
    always_comb begin
        done_c       = 1'b0;
        done_err_c   = 1'b0;
        done_owner_c = cmd.owner;
        done_we_c    = cmd.we;
        done_data_c  = '0;
        case (state)
            ARB_IDLE: begin
                if (req_any_c && !win_in_range_c) begin
                    done_c       = 1'b1;
                    done_err_c   = 1'b1;
                    done_owner_c = win_c.owner;
                    done_we_c    = win_c.we;
                end
            end
            ARB_MEM: begin
                if (bus.mem_ack) begin
                    done_c      = 1'b1;
                    done_data_c = bus.mem_rdata;
                end else if (to_expired_c) begin
                    done_c     = 1'b1;
                    done_err_c = 1'b1;
                end
            end
            default: begin
                done_c = 1'b0;
            end
        endcase
    end

    // Sequencer: grant, memory access, one-cycle response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            cmd       <= '0;
            gnt_cnt   <= '0;
            mem_req_q <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (req_any_c) begin
                        cmd <= win_c;
                        if ((win_c.owner == ARB_OWN_I) || !bus.i_req) begin
                            gnt_cnt <= '0;
                        end else if (gnt_cnt != GCNT_W'(DATA_MAX)) begin
                            gnt_cnt <= gnt_cnt + GCNT_W'(1);
                        end
                        if (win_in_range_c) begin
                            state     <= ARB_MEM;
                            mem_req_q <= 1'b1;
                        end else begin
                            state <= ARB_RESP;
                        end
                    end else begin
                        gnt_cnt <= '0;
                    end
                end
                ARB_MEM: begin
                    if (done_c) begin
                        state     <= ARB_RESP;
                        mem_req_q <= 1'b0;
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state     <= ARB_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Owner ack, error flag and read data, registered on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ack_q <= done_c && (done_owner_c == ARB_OWN_I);
            d_ack_q <= done_c && (done_owner_c == ARB_OWN_D);
            err_q   <= done_c && done_err_c;
            if (done_c && !done_we_c) begin
                if (done_owner_c == ARB_OWN_I) begin
                    i_rdata_q <= done_data_c;
                end else begin
                    d_rdata_q <= done_data_c;
                end
            end
        end
    end

    assign bus.i_ack      = i_ack_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.bus_err    = err_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = cmd.we;
    assign bus.mem_addr   = cmd.addr;
    assign bus.mem_wdata  = cmd.wdata;
    assign bus.core_stall = (bus.i_req & ~i_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MEM_SIZE (256),
        .TIMEOUT  (16),
        .DATA_MAX (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: optional wait states, writes land at the ack edge.
    logic        mem_auto;
    int          mem_wait;
    int          wait_cnt = 0;
    logic [31:0] mem [256];

    function automatic logic [31:0] mem_init(input int a);
        return (a == 212) ? 32'h8C08_0000 : (32'h1000_0000 | 32'(a));
    endfunction

    always_comb begin
        bus.mem_ack   = mem_auto && bus.mem_req && (wait_cnt >= mem_wait);
        bus.mem_rdata = mem[bus.mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) mem[a] <= mem_init(a);
        end else if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_d;
        logic        got_i;
        logic        got;
        logic        first_d;
        logic [31:0] last_d;
        logic [31:0] i_data;
        int          req_cycles;
        logic        err_at_ack;

        n_d = 0; got_i = 1'b0; got = 1'b0; first_d = 1'b0;
        last_d = '0; i_data = '0; req_cycles = 0; err_at_ack = 1'b0;

        reset       = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        mem_auto    = 1'b1;
        mem_wait    = 0;

        // Reset state
        repeat (3) tick();
        check("rst_i_ack",   bus.i_ack,      0);
        check("rst_d_ack",   bus.d_ack,      0);
        check("rst_bus_err", bus.bus_err,    0);
        check("rst_mem_req", bus.mem_req,    0);
        check("rst_mem_we",  bus.mem_we,     0);
        check("rst_i_rdata", bus.i_rdata,    0);
        check("rst_d_rdata", bus.d_rdata,    0);
        check("rst_stall",   bus.core_stall, 0);
        reset = 1'b0;
        tick();

        // Lone fetch, memory acks in the first cycle
        bus.i_req = 1'b1; bus.i_addr = 212;
        #1 check("t1_stall_c0", bus.core_stall, 1);
        tick();
        check("t1_mem_req_c1",  bus.mem_req,  1);
        check("t1_mem_addr_c1", bus.mem_addr, 212);
        check("t1_mem_we_c1",   bus.mem_we,   0);
        check("t1_i_ack_c1",    bus.i_ack,    0);
        tick();
        check("t1_i_ack_c2",    bus.i_ack,      1);
        check("t1_i_rdata",     bus.i_rdata,    32'h8C08_0000);
        check("t1_bus_err",     bus.bus_err,    0);
        check("t1_d_ack",       bus.d_ack,      0);
        check("t1_stall_c2",    bus.core_stall, 0);
        bus.i_req = 1'b0;
        tick();
        check("t1_i_ack_c3",    bus.i_ack,   0);
        check("t1_mem_req_c3",  bus.mem_req, 0);

        // Simultaneous requests: data write first, fetch 3 cycles later
        bus.i_req = 1'b1; bus.i_addr = 7;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 5; bus.d_wdata = 32'h55;
        tick();
        check("t2_mem_req_c1",   bus.mem_req,   1);
        check("t2_mem_we_c1",    bus.mem_we,    1);
        check("t2_mem_addr_c1",  bus.mem_addr,  5);
        check("t2_mem_wdata_c1", bus.mem_wdata, 32'h55);
        tick();
        check("t2_d_ack_c2",     bus.d_ack,      1);
        check("t2_i_ack_c2",     bus.i_ack,      0);
        check("t2_stall_c2",     bus.core_stall, 1);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        tick();
        check("t2_mem_addr_c4",  bus.mem_addr, 7);
        check("t2_i_ack_c4",     bus.i_ack,    0);
        tick();
        check("t2_i_ack_c5",     bus.i_ack,    1);
        check("t2_i_rdata",      bus.i_rdata,  32'h1000_0007);
        check("t2_d_rdata_keep", bus.d_rdata,  0);
        check("t2_mem_written",  mem[5],       32'h55);
        bus.i_req = 1'b0;
        tick();

        // Fairness: four data grants, then the waiting fetch
        bus.i_req = 1'b1; bus.i_addr = 9;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10;
        for (int k = 0; k < 40 && !got_i; k++) begin
            tick();
            check("t3_ack_excl", 32'(bus.i_ack & bus.d_ack), 0);
            if (bus.d_ack) begin
                last_d = bus.d_rdata;
                n_d++;
                bus.d_addr = bus.d_addr + 32'd1;
            end
            if (bus.i_ack) begin
                got_i  = 1'b1;
                i_data = bus.i_rdata;
            end
        end
        check("t3_d_count", 32'(n_d), 4);
        check("t3_i_seen",  32'(got_i), 1);
        check("t3_i_rdata", i_data, 32'h1000_0009);
        check("t3_last_d",  last_d, 32'h1000_000D);
        // Counter cleared by the fetch grant: data wins the next contest
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (bus.d_ack || bus.i_ack) begin
                got     = 1'b1;
                first_d = bus.d_ack;
            end
        end
        check("t3_cnt_cleared", 32'(first_d), 1);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (2) tick();

        // Range error, plus the last in-range address
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 256;
        tick();
        check("t4_mem_req_c1", bus.mem_req, 0);
        check("t4_d_ack_c1",   bus.d_ack,   1);
        check("t4_bus_err_c1", bus.bus_err, 1);
        check("t4_d_rdata",    bus.d_rdata, 0);
        check("t4_i_rdata",    bus.i_rdata, 32'h1000_0009);
        bus.d_req = 1'b0;
        tick();
        check("t4_d_ack_c2",   bus.d_ack,   0);
        check("t4_bus_err_c2", bus.bus_err, 0);
        check("t4_mem_req_c2", bus.mem_req, 0);
        bus.d_req = 1'b1; bus.d_addr = 255;
        tick();
        check("t4b_mem_req_c1", bus.mem_req, 1);
        tick();
        check("t4b_d_ack",   bus.d_ack,   1);
        check("t4b_bus_err", bus.bus_err, 0);
        check("t4b_d_rdata", bus.d_rdata, 32'h1000_00FF);
        bus.d_req = 1'b0;
        tick();

        // Timeout with no memory ack
        mem_auto = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 3;
        got_i = 1'b0;
        for (int k = 0; k < 40 && !got_i; k++) begin
            tick();
            if (bus.i_ack) begin
                got_i      = 1'b1;
                err_at_ack = bus.bus_err;
                i_data     = bus.i_rdata;
            end else if (bus.mem_req) begin
                req_cycles++;
            end
        end
        check("t5_ack_seen",   32'(got_i), 1);
        check("t5_req_cycles", 32'(req_cycles), 16);
        check("t5_bus_err",    32'(err_at_ack), 1);
        check("t5_i_rdata",    i_data, 0);
        check("t5_mem_req_at_ack", bus.mem_req, 0);
        bus.i_req = 1'b0;
        mem_auto  = 1'b1;
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 4;
        tick();
        tick();
        check("t5_next_d_ack",  bus.d_ack,   1);
        check("t5_next_err",    bus.bus_err, 0);
        check("t5_next_rdata",  bus.d_rdata, 32'h1000_0004);
        bus.d_req = 1'b0;
        tick();

        // Two memory wait states stretch the fetch by two cycles
        mem_wait = 2;
        bus.i_req = 1'b1; bus.i_addr = 7;
        repeat (3) tick();
        check("tw_i_ack_c3", bus.i_ack, 0);
        tick();
        check("tw_i_ack_c4", bus.i_ack,   1);
        check("tw_i_rdata",  bus.i_rdata, 32'h1000_0007);
        bus.i_req = 1'b0;
        mem_wait  = 0;
        tick();

        // Reset in the middle of an access
        mem_auto = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 8;
        tick();
        tick();
        check("t6_mem_req_pre", bus.mem_req, 1);
        reset = 1'b1;
        #1;
        check("t6_mem_req_rst", bus.mem_req, 0);
        check("t6_i_ack_rst",   bus.i_ack,   0);
        check("t6_d_ack_rst",   bus.d_ack,   0);
        check("t6_err_rst",     bus.bus_err, 0);
        bus.i_req = 1'b0;
        mem_auto  = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.i_req = 1'b1; bus.i_addr = 212;
        tick();
        tick();
        check("t6_fresh_ack",   bus.i_ack,   1);
        check("t6_fresh_rdata", bus.i_rdata, 32'h8C08_0000);
        check("t6_fresh_err",   bus.bus_err, 0);
        bus.i_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
